// File: rtl/uart_rx_cfg.sv
// Runtime-configurable 16x oversampling UART receiver with framing FSM,
// break detection and a first-word-fall-through receive FIFO.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int AF_LEVEL   = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rx_en,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          d_out,
    output logic                          perr_out,
    output logic                          ferr_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          break_det,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // Nonzero when the received ones count disagrees with the parity mode.
    function automatic logic calc_perr(input logic [DATA_BITS-1:0] data,
                                       input logic pbit, input logic odd);
        return (^data) ^ pbit ^ odd;
    endfunction

    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_sync_s;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d, div_max_s;
    logic                 tick_s;

    state_t               state_q, state_d;
    logic [3:0]           smp_cnt_q, smp_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_err_q, stop_err_d;
    logic                 stop_low_q, stop_low_d;
    logic                 stop_err_s, stop_low_s;
    logic                 wr_pend_q, wr_pend_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 wr_perr_q, wr_perr_d;
    logic                 wr_ferr_q, wr_ferr_d;
    logic                 brk_q, brk_d;
    logic                 busy_q;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d, remain_s;
    logic                 do_rd_s, do_wr_s, drop_s;
    logic [EW-1:0]        wr_word_s, head_d;
    logic [DATA_BITS-1:0] dout_q;
    logic                 perr_out_q, ferr_out_q;
    logic                 empty_q, full_q, af_q, ovf_q, ovf_d;

    assign rx_sync_s = rx_s2_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Baud divider; >= keeps the counter sane if baud_div shrinks while idle.
    always_comb begin
        div_max_s = (baud_div == DIV_WIDTH'(0)) ? DIV_WIDTH'(0) : baud_div - DIV_WIDTH'(1);
        tick_s    = rx_en && (div_cnt_q >= div_max_s);
        if (!rx_en) begin
            div_cnt_d = DIV_WIDTH'(0);
        end else if (tick_s) begin
            div_cnt_d = DIV_WIDTH'(0);
        end else begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
    end

    // Framing FSM: next state, sample shifting and the pending FIFO write.
    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = tick_s ? smp_cnt_q + 4'd1 : smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        stop_err_d = stop_err_q;
        stop_low_d = stop_low_q;
        stop_err_s = stop_err_q | ~rx_sync_s;
        stop_low_s = stop_low_q & ~rx_sync_s;
        wr_pend_d  = 1'b0;
        wr_data_d  = wr_data_q;
        wr_perr_d  = wr_perr_q;
        wr_ferr_d  = wr_ferr_q;
        brk_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                smp_cnt_d = 4'd0;
                if (rx_en && rx_prev_q && !rx_sync_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && (smp_cnt_q == 4'd7)) begin
                    smp_cnt_d = 4'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = rx_sync_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (tick_s && (smp_cnt_q == 4'd15)) begin
                    shift_d = {rx_sync_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d  = 4'd0;
                        stop_err_d = 1'b0;
                        stop_low_d = 1'b1;
                        state_d    = parity_en ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (tick_s && (smp_cnt_q == 4'd15)) begin
                    par_bit_d = rx_sync_s;
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (tick_s && (smp_cnt_q == 4'd15)) begin
                    stop_err_d = stop_err_s;
                    stop_low_d = stop_low_s;
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = 4'd0;
                        wr_pend_d = 1'b1;
                        wr_data_d = shift_q;
                        wr_perr_d = parity_en & calc_perr(shift_q, par_bit_q, parity_odd);
                        wr_ferr_d = stop_err_s;
                        brk_d     = (shift_q == {DATA_BITS{1'b0}}) &&
                                    (!parity_en || !par_bit_q) && stop_low_s;
                        state_d   = stop_err_s ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                state_d = rx_sync_s ? S_IDLE : S_WAIT_HIGH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!rx_en && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            wr_pend_d = 1'b0;
            brk_d     = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= DIV_WIDTH'(0);
            state_q    <= S_IDLE;
            smp_cnt_q  <= 4'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= {DATA_BITS{1'b0}};
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
            stop_low_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= {DATA_BITS{1'b0}};
            wr_perr_q  <= 1'b0;
            wr_ferr_q  <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop_err_q <= stop_err_d;
            stop_low_q <= stop_low_d;
            wr_pend_q  <= wr_pend_d;
            wr_data_q  <= wr_data_d;
            wr_perr_q  <= wr_perr_d;
            wr_ferr_q  <= wr_ferr_d;
            brk_q      <= brk_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // FIFO control; a read frees the slot so a write into a full FIFO succeeds.
    always_comb begin
        wr_word_s = {wr_data_q, wr_perr_q, wr_ferr_q};
        do_rd_s   = rd_en && (cnt_q != CW'(0));
        do_wr_s   = wr_pend_q && ((cnt_q != CW'(FIFO_DEPTH)) || do_rd_s);
        drop_s    = wr_pend_q && !do_wr_s;
        wr_ptr_d  = do_wr_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = do_rd_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
        remain_s  = cnt_q - CW'(do_rd_s);
        case ({do_wr_s, do_rd_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (cnt_d == CW'(0)) begin
            head_d = {dout_q, perr_out_q, ferr_out_q};
        end else if (remain_s == CW'(0)) begin
            head_d = wr_word_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
        end else if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_word_s;
        end
    end

    // FIFO pointers, level and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= PW'(0);
            rd_ptr_q   <= PW'(0);
            cnt_q      <= CW'(0);
            dout_q     <= {DATA_BITS{1'b0}};
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            {dout_q, perr_out_q, ferr_out_q} <= head_d;
            empty_q    <= (cnt_d == CW'(0));
            full_q     <= (cnt_d == CW'(FIFO_DEPTH));
            af_q       <= (cnt_d >= CW'(AF_LEVEL));
            ovf_q      <= ovf_d;
        end
    end

    assign d_out       = dout_q;
    assign perr_out    = perr_out_q;
    assign ferr_out    = ferr_out_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign count       = cnt_q;
    assign overflow    = ovf_q;
    assign break_det   = brk_q;
    assign busy        = busy_q;

endmodule
